hazard_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage (F/D/E/M/W) ARM core.
- Generates the E-stage operand forwarding selects, the load-use stall, and the branch/PC-write flushes.
- Tracks in-flight PC-writing instructions (PCS) through E/M/W, qualifying the E-stage copy with CondExE from the execute-stage condition unit.
- Keeps saturating stall/flush performance counters.
- Sits beside the datapath. Consumes register addresses and control from the D/E/M/W pipeline registers. Drives stall/flush enables back to the F/D/E registers.

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_pcs_tracker.sv | 42 ++++
 rtl/hazard_unit.sv | 111 +++++++++++
 tb/tb_hazard_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hazard_unit_pkg;

    localparam int RF_AW_DEF = 4;

    // E-stage operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read
    localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM

    // R15 reads return PC+8 from the datapath and must never be bypassed
    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_unit_pcs_tracker.sv
// Tracks in-flight PC-writing instructions through E/M/W.
// Latency: PCSrcW rises 3 clk edges after PCSD is sampled high (if CondExE held in E).
// Backpressure: none; FlushE squashes the D->E hop, failed CondExE squashes E->M.
//
// Ports:
//   clk, reset    : core clock, synchronous active-high reset
//   PCSD          : D instruction writes PC (unconditioned)
//   FlushE        : D/E register is being cleared this cycle
//   CondExE       : condition passed for the E instruction
//   PCWrPendingF  : a PC write is in D, E or M (fetch must hold)
//   PCSrcW        : a PC write retires in W
module hazard_unit_pcs_tracker (
    input  logic clk,
    input  logic reset,
    input  logic PCSD,
    input  logic FlushE,
    input  logic CondExE,
    output logic PCWrPendingF,
    output logic PCSrcW
);

    logic pcs_e;
    logic pcs_m;
    logic pcs_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcs_e <= 1'b0;
            pcs_m <= 1'b0;
            pcs_w <= 1'b0;
        end else begin
            pcs_e <= FlushE ? 1'b0 : PCSD;
            // The E copy only becomes real once its condition resolves
            pcs_m <= pcs_e & CondExE;
            pcs_w <= pcs_m;
        end
    end

    assign PCWrPendingF = PCSD | pcs_e | pcs_m;
    assign PCSrcW       = pcs_w;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: E-stage forwarding, load-use stall, PC-write/branch flushes.
// Latency: forward/stall/flush combinational same cycle; PCSrcW 3 edges after PCSD.
// Backpressure: StallF/StallD hold F and F/D; FlushD/FlushE clear F/D and D/E.
//
// Ports:
//   clk, reset                 : core clock, synchronous active-high reset
//   RA1D/RA2D                  : D-stage source registers
//   RA1E/RA2E, WA3E            : E-stage sources and destination
//   WA3M, WA3W                 : M/W destinations
//   RegWriteE/M/W              : condition-qualified register writes
//   MemtoRegE                  : E instruction is a load
//   PCSD, CondExE, BranchTakenE: PC-write / condition / taken-branch control
//   ForwardAE/BE               : SrcA/SrcB selects (00 RF, 01 ResultW, 10 ALUResultM)
//   StallF, StallD, FlushD, FlushE, PCSrcW : pipeline control
//   StallCnt, FlushCnt         : saturating cycle counts of StallF / FlushE
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RF_AW = RF_AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RF_AW-1:0] RA1D,
    input  logic [RF_AW-1:0] RA2D,
    input  logic [RF_AW-1:0] RA1E,
    input  logic [RF_AW-1:0] RA2E,
    input  logic [RF_AW-1:0] WA3E,
    input  logic [RF_AW-1:0] WA3M,
    input  logic [RF_AW-1:0] WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSD,
    input  logic             CondExE,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             PCSrcW,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [RF_AW-1:0] PC_ADDR = RF_AW'(REG_PC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic ldr_stall;
    logic pc_wr_pending_f;

    // M is the younger result, so it wins over W when both match
    always_comb begin
        ForwardAE = FWD_RF;
        if (RA1E != PC_ADDR) begin
            if (RegWriteM && (RA1E == WA3M))
                ForwardAE = FWD_MEM;
            else if (RegWriteW && (RA1E == WA3W))
                ForwardAE = FWD_WB;
        end
    end

    always_comb begin
        ForwardBE = FWD_RF;
        if (RA2E != PC_ADDR) begin
            if (RegWriteM && (RA2E == WA3M))
                ForwardBE = FWD_MEM;
            else if (RegWriteW && (RA2E == WA3W))
                ForwardBE = FWD_WB;
        end
    end

    // A load into R15 is a PC write, handled by the PCS path, not a load-use bubble
    assign ldr_stall = MemtoRegE & RegWriteE
                     & ((RA1D == WA3E) | (RA2D == WA3E))
                     & (WA3E != PC_ADDR);

    hazard_unit_pcs_tracker u_pcs_tracker (
        .clk          (clk),
        .reset        (reset),
        .PCSD         (PCSD),
        .FlushE       (FlushE),
        .CondExE      (CondExE),
        .PCWrPendingF (pc_wr_pending_f),
        .PCSrcW       (PCSrcW)
    );

    assign StallD = ldr_stall;
    assign StallF = ldr_stall | pc_wr_pending_f;
    // With a load-use stall and taken branch together, D/E flush overrides its stall
    assign FlushE = ldr_stall | BranchTakenE;
    assign FlushD = pc_wr_pending_f | PCSrcW | BranchTakenE;

    always_ff @(posedge clk) begin
        if (reset)
            StallCnt <= '0;
        else if (StallF && (StallCnt != CNT_MAX))
            StallCnt <= StallCnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            FlushCnt <= '0;
        else if (FlushE && (FlushCnt != CNT_MAX))
            FlushCnt <= FlushCnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSD, CondExE, BranchTakenE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE, PCSrcW;
    logic [15:0] StallCnt, FlushCnt;

    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_StallF, s_StallD, s_FlushD, s_FlushE, s_PCSrcW;
    logic [3:0]  s_StallCnt, s_FlushCnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16), .RF_AW(4)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSD(PCSD), .CondExE(CondExE),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcW(PCSrcW), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    // Narrow-counter instance for the saturation case
    hazard_unit #(.CNT_W(4), .RF_AW(4)) dut_small (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSD(PCSD), .CondExE(CondExE),
        .BranchTakenE(BranchTakenE),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .PCSrcW(s_PCSrcW), .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
    );

    typedef struct {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwe, rwm, rww, m2r, bte;
        logic [1:0] fae, fbe;
        logic       stf, std, fld, fle;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSD = 0; CondExE = 0; BranchTakenE = 0;
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_loaduse();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA2D = 4'd5;
    endtask

    initial begin
        //          ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwe rwm rww m2r bte  fae    fbe   stf std fld fle
        vecs[0]  = '{0,  0,   0,   0,   0,   0,   0,   0,  0,  0,  0,  0,  2'b00, 2'b00, 0, 0, 0, 0};
        vecs[1]  = '{0,  0,   3,   0,   0,   3,   3,   0,  1,  1,  0,  0,  2'b10, 2'b00, 0, 0, 0, 0};
        vecs[2]  = '{0,  0,   3,   0,   0,   3,   3,   0,  0,  1,  0,  0,  2'b01, 2'b00, 0, 0, 0, 0};
        vecs[3]  = '{0,  0,   15,  0,   0,   15,  15,  0,  1,  1,  0,  0,  2'b00, 2'b00, 0, 0, 0, 0};
        vecs[4]  = '{0,  0,   0,   7,   0,   1,   7,   0,  1,  1,  0,  0,  2'b00, 2'b01, 0, 0, 0, 0};
        vecs[5]  = '{0,  0,   2,   2,   0,   2,   9,   0,  1,  1,  0,  0,  2'b10, 2'b10, 0, 0, 0, 0};
        vecs[6]  = '{0,  0,   4,   4,   0,   4,   4,   0,  0,  0,  0,  0,  2'b00, 2'b00, 0, 0, 0, 0};
        vecs[7]  = '{5,  1,   0,   0,   5,   0,   0,   1,  0,  0,  1,  0,  2'b00, 2'b00, 1, 1, 0, 1};
        vecs[8]  = '{15, 1,   0,   0,   15,  0,   0,   1,  0,  0,  1,  0,  2'b00, 2'b00, 0, 0, 0, 0};
        vecs[9]  = '{5,  1,   0,   0,   5,   0,   0,   0,  0,  0,  1,  0,  2'b00, 2'b00, 0, 0, 0, 0};
        vecs[10] = '{5,  1,   0,   0,   5,   0,   0,   1,  0,  0,  0,  0,  2'b00, 2'b00, 0, 0, 0, 0};
        vecs[11] = '{0,  0,   0,   0,   6,   0,   0,   0,  0,  0,  0,  1,  2'b00, 2'b00, 0, 0, 1, 1};
        vecs[12] = '{1,  6,   0,   0,   6,   0,   0,   1,  0,  0,  1,  1,  2'b00, 2'b00, 1, 1, 1, 1};
        vecs[13] = '{0,  0,   8,   15,  0,   15,  8,   0,  1,  1,  0,  0,  2'b01, 2'b00, 0, 0, 0, 0};

        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_StallF",   StallF,   0);
        check("rst_FlushD",   FlushD,   0);
        check("rst_FlushE",   FlushE,   0);
        check("rst_PCSrcW",   PCSrcW,   0);
        check("rst_StallCnt", StallCnt, 0);
        check("rst_FlushCnt", FlushCnt, 0);
        check("rst_FwdA",     ForwardAE, 0);

        // Combinational vectors (PC tracker idle throughout)
        for (int i = 0; i < 14; i++) begin
            tick();
            RA1D = vecs[i].ra1d; RA2D = vecs[i].ra2d; RA1E = vecs[i].ra1e; RA2E = vecs[i].ra2e;
            WA3E = vecs[i].wa3e; WA3M = vecs[i].wa3m; WA3W = vecs[i].wa3w;
            RegWriteE = vecs[i].rwe; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemtoRegE = vecs[i].m2r; BranchTakenE = vecs[i].bte;
            PCSD = 0; CondExE = 0;
            #1;
            check($sformatf("v%0d_ForwardAE", i), ForwardAE, vecs[i].fae);
            check($sformatf("v%0d_ForwardBE", i), ForwardBE, vecs[i].fbe);
            check($sformatf("v%0d_StallF", i),    StallF,    vecs[i].stf);
            check($sformatf("v%0d_StallD", i),    StallD,    vecs[i].std);
            check($sformatf("v%0d_FlushD", i),    FlushD,    vecs[i].fld);
            check($sformatf("v%0d_FlushE", i),    FlushE,    vecs[i].fle);
        end

        // Load-use: one stalled cycle, both counters +1
        do_reset();
        set_loaduse();
        #1;
        check("lu_StallF", StallF, 1);
        check("lu_StallD", StallD, 1);
        check("lu_FlushE", FlushE, 1);
        check("lu_StallCnt_before", StallCnt, 0);
        tick();
        clear_inputs();
        #1;
        check("lu_StallF_after", StallF, 0);
        check("lu_StallCnt", StallCnt, 1);
        check("lu_FlushCnt", FlushCnt, 1);

        // Taken PC write: StallF 3 cycles, FlushD 4 cycles, PCSrcW after 3rd edge
        do_reset();
        PCSD = 1;
        #1;
        check("pcw_c0_StallF", StallF, 1);
        check("pcw_c0_FlushD", FlushD, 1);
        check("pcw_c0_PCSrcW", PCSrcW, 0);
        tick();
        PCSD = 0; CondExE = 1;
        #1;
        check("pcw_c1_StallF", StallF, 1);
        check("pcw_c1_FlushD", FlushD, 1);
        tick();
        CondExE = 0;
        #1;
        check("pcw_c2_StallF", StallF, 1);
        check("pcw_c2_FlushD", FlushD, 1);
        check("pcw_c2_PCSrcW", PCSrcW, 0);
        tick();
        #1;
        check("pcw_c3_StallF", StallF, 0);
        check("pcw_c3_FlushD", FlushD, 1);
        check("pcw_c3_PCSrcW", PCSrcW, 1);
        tick();
        #1;
        check("pcw_c4_FlushD", FlushD, 0);
        check("pcw_c4_PCSrcW", PCSrcW, 0);
        check("pcw_StallCnt",  StallCnt, 3);
        check("pcw_FlushCnt",  FlushCnt, 0);

        // Failed-condition PC write: StallF exactly 2 cycles, PCSrcW never
        do_reset();
        PCSD = 1;
        #1;
        check("pcf_c0_StallF", StallF, 1);
        tick();
        PCSD = 0; CondExE = 0;
        #1;
        check("pcf_c1_StallF", StallF, 1);
        tick();
        #1;
        check("pcf_c2_StallF", StallF, 0);
        check("pcf_c2_FlushD", FlushD, 0);
        tick();
        #1;
        check("pcf_c3_PCSrcW", PCSrcW, 0);
        tick();
        #1;
        check("pcf_c4_PCSrcW", PCSrcW, 0);
        check("pcf_StallCnt",  StallCnt, 2);

        // Saturation on the 4-bit instance
        do_reset();
        set_loaduse();
        for (int i = 0; i < 16; i++) tick();
        check("sat16_small_StallCnt", s_StallCnt, 15);
        for (int i = 0; i < 4; i++) tick();
        check("sat20_small_StallCnt", s_StallCnt, 15);
        check("sat20_small_FlushCnt", s_FlushCnt, 15);
        check("sat20_wide_StallCnt",  StallCnt, 20);
        clear_inputs();

        // Reset mid-stall with pcs_m=1 and StallCnt=7
        do_reset();
        set_loaduse();
        for (int i = 0; i < 5; i++) tick();
        clear_inputs();
        PCSD = 1;
        tick();
        PCSD = 0; CondExE = 1;
        tick();
        CondExE = 0;
        #1;
        check("rms_pre_StallCnt", StallCnt, 7);
        check("rms_pre_FlushCnt", FlushCnt, 5);
        check("rms_pre_StallF",   StallF, 1);
        reset = 1'b1;
        tick();
        #1;
        check("rms_StallCnt", StallCnt, 0);
        check("rms_FlushCnt", FlushCnt, 0);
        check("rms_PCSrcW",   PCSrcW, 0);
        check("rms_StallF",   StallF, 0);
        check("rms_FlushD",   FlushD, 0);
        reset = 1'b0;
        tick();
        #1;
        check("rms_post_PCSrcW",   PCSrcW, 0);
        check("rms_post_StallCnt", StallCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
